tile_line_fetcher: RTL and testbench

- Reads one scanline of the tile background from the tile buffer and tile graphics memories.
- Emits 40 rows of 16 colour indices each, one per 16-pixel tile column, toward the scanline line buffer.
- Sits between the video timing controller (which pulses `start` in horizontal blanking) and the palette lookup stage.
- Drives the read side (port 2, write-enable tied low) of both memories.

---
 rtl/tile_line_fetcher_if.sv | 38 +++
 rtl/tile_line_fetcher.sv | 151 +++++++++++++++
 tb/tb_tile_line_fetcher.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_line_fetcher_if.sv
// tile_line_fetcher_if
//   Groups the fetcher's request/status, memory read-port and row-output
//   signals. The master modport is the fetcher. The slave modport is the
//   surrounding system: the timing controller, both memories and the line
//   buffer.
//   start/line       request to fetch one scanline
//   busy/done        fetch in progress / one-cycle completion pulse
//   tb_*             tile buffer read port (9-bit word address)
//   gfx_*            tile graphics read port (11-bit word address)
//   row_*            one 16-pixel tile row per row_we strobe
interface tile_line_fetcher_if;
  logic        start;
  logic [8:0]  line;
  logic        busy;
  logic        done;
  logic [8:0]  tb_addr;
  logic        tb_rw;
  logic [31:0] tb_rdata;
  logic [10:0] gfx_addr;
  logic        gfx_rw;
  logic [31:0] gfx_rdata;
  logic        row_we;
  logic [5:0]  row_tile;
  logic [47:0] row_data;
  logic [15:0] row_mask;

  modport master (
    input  start, line, tb_rdata, gfx_rdata,
    output busy, done, tb_addr, tb_rw, gfx_addr, gfx_rw,
           row_we, row_tile, row_data, row_mask
  );

  modport slave (
    output start, line, tb_rdata, gfx_rdata,
    input  busy, done, tb_addr, tb_rw, gfx_addr, gfx_rw,
           row_we, row_tile, row_data, row_mask
  );
endinterface

// File: rtl/tile_line_fetcher.sv
// tile_line_fetcher
//   Fetches one scanline of the tile background. It emits 40 rows of 16
//   3-bit colour indices, one row per 16-pixel tile column. Each group of
//   4 tiles needs one tile-buffer read, and each tile needs one graphics read.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    tile_line_fetcher_if.master (request, memory reads, row output)
//   Optional build macro:
//     TILE_TRANSPARENCY_EN  when defined, row_mask marks pixels whose 2-bit
//                           value is 00 as transparent. When undefined,
//                           row_mask is always 16'hFFFF.
module tile_line_fetcher #(
  parameter int unsigned SCREEN_LINES   = 480,
  parameter int unsigned TILES_PER_LINE = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  tile_line_fetcher_if.master  bus
);

  localparam logic [8:0] LINE_LIMIT = 9'(SCREEN_LINES);
  localparam logic [5:0] LAST_TILE  = 6'(TILES_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE, TB_ADDR, TB_DATA, GFX_ADDR, GFX_DATA, EMIT
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic [8:0]  line_q;
  logic [5:0]  tile_x;
  logic [5:0]  tile_next;
  logic        last_tile;
  logic [31:0] word_q;
  logic        pal_q;
  logic [31:0] entry_src;
  logic [1:0]  entry_idx;
  logic [7:0]  entry;
  logic [47:0] row_data_next;
  logic [15:0] row_mask_next;

  function automatic logic [8:0] tb_word(input logic [4:0] tile_row,
                                         input logic [3:0] group);
    return 9'(tile_row) * 9'd10 + 9'(group);
  endfunction

  assign bus.tb_rw  = 1'b0;
  assign bus.gfx_rw = 1'b0;
  assign bus.busy   = (state != IDLE);
  assign bus.row_we = (state == EMIT);

  assign tile_next = tile_x + 6'd1;
  assign last_tile = (tile_x == LAST_TILE);

  // gfx_addr is registered on entry to GFX_ADDR. From TB_DATA the entry
  // comes straight off the tile buffer read data, because word_q is
  // captured on that same edge. From EMIT the entry comes from the
  // latched word, indexed by the next tile column.
  assign entry_src = (state == TB_DATA) ? bus.tb_rdata : word_q;
  assign entry_idx = (state == TB_DATA) ? tile_x[1:0] : tile_next[1:0];
  assign entry     = entry_src[{entry_idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && (bus.line < LINE_LIMIT)) begin
          accept     = 1'b1;
          state_next = TB_ADDR;
        end
      end
      TB_ADDR:  state_next = TB_DATA;
      TB_DATA:  state_next = GFX_ADDR;
      GFX_ADDR: state_next = GFX_DATA;
      GFX_DATA: state_next = EMIT;
      EMIT: begin
        if (last_tile)                 state_next = IDLE;
        else if (tile_next[1:0] == '0) state_next = TB_ADDR;
        else                           state_next = GFX_ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    row_data_next = '0;
    row_mask_next = '1;
    for (int unsigned p = 0; p < 16; p++) begin
      row_data_next[3*p +: 3] = {pal_q, bus.gfx_rdata[2*p +: 2]};
`ifdef TILE_TRANSPARENCY_EN
      row_mask_next[p] = |bus.gfx_rdata[2*p +: 2];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q       <= '0;
      tile_x       <= '0;
      word_q       <= '0;
      pal_q        <= 1'b0;
      bus.tb_addr  <= '0;
      bus.gfx_addr <= '0;
      bus.row_tile <= '0;
      bus.row_data <= '0;
      bus.row_mask <= '1;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= (state == EMIT) && last_tile;
      case (state)
        IDLE: begin
          if (accept) begin
            line_q      <= bus.line;
            tile_x      <= '0;
            bus.tb_addr <= tb_word(bus.line[8:4], 4'd0);
          end
        end
        TB_DATA: begin
          word_q       <= bus.tb_rdata;
          pal_q        <= entry[7];
          bus.gfx_addr <= {entry[6:0], line_q[3:0]};
        end
        GFX_DATA: begin
          bus.row_data <= row_data_next;
          bus.row_mask <= row_mask_next;
          bus.row_tile <= tile_x;
        end
        EMIT: begin
          if (!last_tile) begin
            tile_x <= tile_next;
            if (tile_next[1:0] == '0) begin
              bus.tb_addr <= tb_word(line_q[8:4], tile_next[5:2]);
            end else begin
              pal_q        <= entry[7];
              bus.gfx_addr <= {entry[6:0], line_q[3:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_line_fetcher.sv
// tb_tile_line_fetcher
//   Self-checking bench for tile_line_fetcher. It models both memories as
//   one-cycle-latency arrays. It derives the expected rows and strobe
//   timing from the tile-buffer and graphics formats.
module tb_tile_line_fetcher;
  localparam int NCYC = 150;

  logic clk = 1'b0;
  logic reset;

  tile_line_fetcher_if bus ();

  tile_line_fetcher #(.SCREEN_LINES(480), .TILES_PER_LINE(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem  [0:511];
  logic [31:0] gfx_mem [0:2047];

  always @(posedge clk) begin
    bus.tb_rdata  <= tb_mem[bus.tb_addr];
    bus.gfx_rdata <= gfx_mem[bus.gfx_addr];
  end

  int checks = 0;
  int failures = 0;

  int          cap_we_cnt;
  int          cap_we_cyc [64];
  logic [5:0]  cap_tile   [64];
  logic [47:0] cap_data   [64];
  logic [15:0] cap_mask   [64];
  int          cap_done_cnt;
  int          cap_done_cyc;
  logic        cap_busy   [NCYC+1];
  logic [8:0]  cap_tba    [NCYC+1];
  logic [10:0] cap_gfa    [NCYC+1];
  logic [4:0]  snap_flags;
  logic [5:0]  snap_tile;
  logic [47:0] snap_data;
  logic [15:0] snap_mask;
  logic [8:0]  snap_tba;
  logic [10:0] snap_gfa;

  // Reference model: straight from the memory formats.
  function automatic logic [7:0] m_entry(int ln, int x);
    logic [31:0] w;
    w = tb_mem[(ln / 16) * 10 + x / 4];
    return w[8 * (x % 4) +: 8];
  endfunction

  function automatic logic [31:0] m_gfx(int ln, int x);
    logic [7:0] e;
    e = m_entry(ln, x);
    return gfx_mem[int'(e[6:0]) * 16 + ln % 16];
  endfunction

  function automatic logic [47:0] m_data(int ln, int x);
    logic [7:0]  e;
    logic [31:0] g;
    logic [47:0] d;
    e = m_entry(ln, x);
    g = m_gfx(ln, x);
    d = '0;
    for (int p = 0; p < 16; p++) d[3*p +: 3] = {e[7], g[2*p +: 2]};
    return d;
  endfunction

  function automatic logic [15:0] m_mask(int ln, int x);
    logic [15:0] m;
`ifdef TILE_TRANSPARENCY_EN
    logic [31:0] g;
    g = m_gfx(ln, x);
    for (int p = 0; p < 16; p++) m[p] = (g[2*p +: 2] != 2'b00);
`else
    m = '1;
`endif
    return m;
  endfunction

  function automatic int m_we_cyc(int i);
    return 5 + 14 * (i / 4) + 3 * (i % 4);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 512; i++)  tb_mem[i]  = '0;
    for (int i = 0; i < 2048; i++) gfx_mem[i] = '0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 512; i++)  tb_mem[i]  = $urandom;
    for (int i = 0; i < 2048; i++) gfx_mem[i] = $urandom;
  endtask

  // Pulses start with line ln in cycle T, then records NCYC cycles of outputs.
  // Cycle T+n is sampled at the n-th falling edge after the sampling edge.
  // repulse_at pulses start (line 7) in cycle T+n.
  // reset_at asserts reset for one cycle in cycle T+n.
  task automatic capture(input int ln, input int repulse_at, input int reset_at);
    cap_we_cnt   = 0;
    cap_done_cnt = 0;
    cap_done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.line  = 9'(ln);
    @(posedge clk);
    for (int n = 1; n <= NCYC; n++) begin
      @(negedge clk);
      bus.start = (n == repulse_at);
      if (n == repulse_at) bus.line = 9'd7;
      if (reset_at != 0 && n == reset_at + 1) reset = 1'b0;
      if (reset_at != 0 && n == reset_at) begin
        reset = 1'b1;
        #1;
        snap_flags = {bus.busy, bus.done, bus.row_we, bus.tb_rw, bus.gfx_rw};
        snap_tile  = bus.row_tile;
        snap_data  = bus.row_data;
        snap_mask  = bus.row_mask;
        snap_tba   = bus.tb_addr;
        snap_gfa   = bus.gfx_addr;
      end
      cap_busy[n] = bus.busy;
      cap_tba[n]  = bus.tb_addr;
      cap_gfa[n]  = bus.gfx_addr;
      if (bus.row_we === 1'b1) begin
        if (cap_we_cnt < 64) begin
          cap_we_cyc[cap_we_cnt] = n;
          cap_tile[cap_we_cnt]   = bus.row_tile;
          cap_data[cap_we_cnt]   = bus.row_data;
          cap_mask[cap_we_cnt]   = bus.row_mask;
        end
        cap_we_cnt++;
      end
      if (bus.done === 1'b1) begin
        cap_done_cnt++;
        cap_done_cyc = n;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.line = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.row_we} !== 3'b000) begin failures++; $display("FAIL reset_flags busy/done/row_we got %b expected 000", {bus.busy, bus.done, bus.row_we}); end
    checks++; if ({bus.tb_rw, bus.gfx_rw} !== 2'b00) begin failures++; $display("FAIL reset_rw got %b expected 00", {bus.tb_rw, bus.gfx_rw}); end
    checks++; if (bus.row_tile !== 6'd0) begin failures++; $display("FAIL reset_row_tile got %0d expected 0", bus.row_tile); end
    checks++; if (bus.row_data !== 48'h0) begin failures++; $display("FAIL reset_row_data got %h expected 0", bus.row_data); end
    checks++; if (bus.row_mask !== 16'hFFFF) begin failures++; $display("FAIL reset_row_mask got %h expected ffff", bus.row_mask); end
    checks++; if (bus.tb_addr !== 9'd0) begin failures++; $display("FAIL reset_tb_addr got %0d expected 0", bus.tb_addr); end
    checks++; if (bus.gfx_addr !== 11'd0) begin failures++; $display("FAIL reset_gfx_addr got %0d expected 0", bus.gfx_addr); end
  endtask

  task automatic test_basic_line();
    int bad_busy;
    clear_mem();
    tb_mem[0]  = 32'h8302_8100;
    gfx_mem[0] = 32'h0000_0001;
    capture(0, 0, 0);
    checks++; if (cap_we_cnt !== 40) begin failures++; $display("FAIL basic_row_count got %0d expected 40", cap_we_cnt); end
    checks++; if (cap_done_cnt !== 1 || cap_done_cyc !== 141) begin failures++; $display("FAIL basic_done got count %0d cycle %0d expected 1 at 141", cap_done_cnt, cap_done_cyc); end
    checks++; if (cap_we_cyc[0] !== 5 || cap_tile[0] !== 6'd0 || cap_data[0] !== 48'h1) begin failures++; $display("FAIL basic_tile0 got cyc %0d tile %0d data %h expected 5 0 000000000001", cap_we_cyc[0], cap_tile[0], cap_data[0]); end
    checks++; if (cap_we_cyc[1] !== 8 || cap_tile[1] !== 6'd1 || cap_data[1] !== 48'h924924924924) begin failures++; $display("FAIL basic_tile1 got cyc %0d tile %0d data %h expected 8 1 924924924924", cap_we_cyc[1], cap_tile[1], cap_data[1]); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_we_cyc[i] !== m_we_cyc(i) || cap_tile[i] !== 6'(i) || cap_data[i] !== m_data(0, i) || cap_mask[i] !== m_mask(0, i)) begin
        failures++;
        $display("FAIL basic_row%0d got cyc %0d tile %0d data %h mask %h expected cyc %0d tile %0d data %h mask %h", i, cap_we_cyc[i], cap_tile[i], cap_data[i], cap_mask[i], m_we_cyc(i), i, m_data(0, i), m_mask(0, i));
      end
    end
    bad_busy = 0;
    for (int n = 1; n <= NCYC; n++) if (cap_busy[n] !== (n <= 140)) bad_busy++;
    checks++; if (bad_busy !== 0) begin failures++; $display("FAIL basic_busy got %0d bad cycles expected 0 (busy 1..140 only)", bad_busy); end
  endtask

  task automatic test_random_lines();
    int ln;
    for (int t = 0; t < 3; t++) begin
      fill_random();
      ln = (t == 0) ? 0 : $urandom_range(1, 479);
      capture(ln, 0, 0);
      checks++; if (cap_we_cnt !== 40 || cap_done_cyc !== 141) begin failures++; $display("FAIL rand_line%0d got rows %0d done %0d expected 40 141", ln, cap_we_cnt, cap_done_cyc); end
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (cap_we_cyc[i] !== m_we_cyc(i) || cap_tile[i] !== 6'(i) || cap_data[i] !== m_data(ln, i) || cap_mask[i] !== m_mask(ln, i)) begin
          failures++;
          $display("FAIL rand_line%0d_row%0d got cyc %0d tile %0d data %h mask %h expected cyc %0d data %h mask %h", ln, i, cap_we_cyc[i], cap_tile[i], cap_data[i], cap_mask[i], m_we_cyc(i), m_data(ln, i), m_mask(ln, i));
        end
      end
    end
  endtask

  task automatic test_last_line();
    int bad_nib;
    fill_random();
    capture(479, 0, 0);
    checks++; if (cap_tba[1] !== 9'd290) begin failures++; $display("FAIL last_line_first_tb_addr got %0d expected 290", cap_tba[1]); end
    checks++; if (cap_tba[140] !== 9'd299) begin failures++; $display("FAIL last_line_last_tb_addr got %0d expected 299", cap_tba[140]); end
    bad_nib = 0;
    for (int i = 0; i < 40; i++) if (cap_gfa[m_we_cyc(i) - 2][3:0] !== 4'hF) bad_nib++;
    checks++; if (bad_nib !== 0) begin failures++; $display("FAIL last_line_gfx_nibble got %0d bad addresses expected 0", bad_nib); end
    checks++; if (cap_we_cnt !== 40 || cap_data[39] !== m_data(479, 39)) begin failures++; $display("FAIL last_line_rows got %0d rows last %h expected 40 %h", cap_we_cnt, cap_data[39], m_data(479, 39)); end
  endtask

  task automatic test_out_of_range();
    int any_busy;
    for (int t = 0; t < 2; t++) begin
      capture((t == 0) ? 480 : $urandom_range(481, 511), 0, 0);
      any_busy = 0;
      for (int n = 1; n <= NCYC; n++) if (cap_busy[n] !== 1'b0) any_busy++;
      checks++; if (any_busy !== 0 || cap_we_cnt !== 0 || cap_done_cnt !== 0) begin failures++; $display("FAIL out_of_range got busy %0d rows %0d done %0d expected 0 0 0", any_busy, cap_we_cnt, cap_done_cnt); end
    end
  endtask

  task automatic test_restart_ignored();
    int ln;
    fill_random();
    ln = $urandom_range(16, 479);
    capture(ln, 50, 0);
    checks++; if (cap_we_cnt !== 40 || cap_done_cnt !== 1 || cap_done_cyc !== 141) begin failures++; $display("FAIL restart got rows %0d done %0d at %0d expected 40 1 141", cap_we_cnt, cap_done_cnt, cap_done_cyc); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_we_cyc[i] !== m_we_cyc(i) || cap_data[i] !== m_data(ln, i)) begin
        failures++;
        $display("FAIL restart_row%0d got cyc %0d data %h expected cyc %0d data %h", i, cap_we_cyc[i], cap_data[i], m_we_cyc(i), m_data(ln, i));
      end
    end
  endtask

  task automatic test_reset_abort();
    int ln;
    fill_random();
    ln = $urandom_range(0, 479);
    capture(ln, 0, 30);
    checks++; if (snap_flags !== 5'b0 || snap_tile !== 6'd0 || snap_data !== 48'h0) begin failures++; $display("FAIL abort_snapshot got flags %b tile %0d data %h expected 00000 0 0", snap_flags, snap_tile, snap_data); end
    checks++; if (snap_mask !== 16'hFFFF || snap_tba !== 9'd0 || snap_gfa !== 11'd0) begin failures++; $display("FAIL abort_snapshot_regs got mask %h tb %0d gfx %0d expected ffff 0 0", snap_mask, snap_tba, snap_gfa); end
    checks++; if (cap_we_cnt !== 8 || cap_done_cnt !== 0) begin failures++; $display("FAIL abort_rows got rows %0d done %0d expected 8 0", cap_we_cnt, cap_done_cnt); end
    ln = $urandom_range(0, 479);
    capture(ln, 0, 0);
    checks++; if (cap_we_cnt !== 40 || cap_done_cyc !== 141) begin failures++; $display("FAIL abort_refetch got rows %0d done %0d expected 40 141", cap_we_cnt, cap_done_cyc); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_tile[i] !== 6'(i) || cap_data[i] !== m_data(ln, i) || cap_mask[i] !== m_mask(ln, i)) begin
        failures++;
        $display("FAIL abort_refetch_row%0d got tile %0d data %h mask %h expected %0d %h %h", i, cap_tile[i], cap_data[i], cap_mask[i], i, m_data(ln, i), m_mask(ln, i));
      end
    end
  endtask

  task automatic test_transparency();
    logic [15:0] exp_mask;
`ifdef TILE_TRANSPARENCY_EN
    exp_mask = 16'h0002;
`else
    exp_mask = 16'hFFFF;
`endif
    clear_mem();
    gfx_mem[0] = 32'h0000_000C;
    capture(0, 0, 0);
    checks++; if (cap_mask[0] !== exp_mask || cap_data[0] !== 48'h18) begin failures++; $display("FAIL transparency got mask %h data %h expected %h 000000000018", cap_mask[0], cap_data[0], exp_mask); end
    checks++; if (cap_mask[39] !== exp_mask) begin failures++; $display("FAIL transparency_last got mask %h expected %h", cap_mask[39], exp_mask); end
  endtask

  task automatic test_back_to_back();
    int ln;
    fill_random();
    ln = $urandom_range(16, 479);
    capture(ln, 141, 0);
    checks++; if (cap_we_cnt !== 42 || cap_done_cyc !== 141) begin failures++; $display("FAIL b2b_count got rows %0d done %0d expected 42 141", cap_we_cnt, cap_done_cyc); end
    checks++; if (cap_we_cyc[40] !== 146 || cap_tile[40] !== 6'd0 || cap_data[40] !== m_data(7, 0)) begin failures++; $display("FAIL b2b_second0 got cyc %0d tile %0d data %h expected 146 0 %h", cap_we_cyc[40], cap_tile[40], cap_data[40], m_data(7, 0)); end
    checks++; if (cap_we_cyc[41] !== 149 || cap_tile[41] !== 6'd1 || cap_data[41] !== m_data(7, 1)) begin failures++; $display("FAIL b2b_second1 got cyc %0d tile %0d data %h expected 149 1 %h", cap_we_cyc[41], cap_tile[41], cap_data[41], m_data(7, 1)); end
    repeat (150) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.line = '0;
    test_reset();
    test_basic_line();
    test_random_lines();
    test_last_line();
    test_out_of_range();
    test_restart_ignored();
    test_reset_abort();
    test_transparency();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
